// File: rtl/sap1_fetch_sequencer.sv
// SAP-1 fetch/decode sequencer: six-state one-hot ring, MAR, IR, operand register, retire counter.
// Latency: one instruction per 6 advancing edges; IR valid after edge 3, operand after edge 5.
// Backpressure: run=0 (or halted) freezes every register; Cp is suppressed while frozen.
module sap1_fetch_sequencer #(
  parameter int          ADDR_W = 4,
  parameter int          DATA_W = 8,
  parameter logic [3:0]  OUT_OP = 4'hE,
  parameter logic [3:0]  HLT_OP = 4'hF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] ram_data,
  output logic              Cp,
  output logic              Ep,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ir_out,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] operand,
  output logic              operand_valid,
  output logic              out_strobe,
  output logic [5:0]        t_state,
  output logic              halted,
  output logic [7:0]        instr_count
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  tstate_t           state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] opr;
  logic              opr_vld;
  logic              hlt;
  logic [7:0]        count;
  logic              advance;
  logic              mem_ref;

  // A clock edge only does work when running and not halted.
  assign advance = run & ~hlt;

  // LDA/ADD/SUB (opcodes 0..2) are the only instructions that touch memory a second time.
  assign mem_ref = (ir[DATA_W-1 -: 4] <= 4'd2);

  // Output decodes come from registered state only, never from ram_data.
  assign t_state       = state;
  assign mem_addr      = mar;
  assign ir_out        = ir;
  assign opcode        = ir[DATA_W-1 -: 4];
  assign operand       = opr;
  assign operand_valid = opr_vld;
  assign halted        = hlt;
  assign instr_count   = count;
  assign Ep            = (state == T1);
  assign Cp            = (state == T2) & advance;
  assign out_strobe    = (state == T4) & (ir[DATA_W-1 -: 4] == OUT_OP) & ~hlt;

  // Ring counter and datapath registers; everything holds unless advancing.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= T1;
      mar     <= '0;
      ir      <= '0;
      opr     <= '0;
      opr_vld <= 1'b0;
      hlt     <= 1'b0;
      count   <= '0;
    end else if (advance) begin
      case (state)
        T1: begin
          mar   <= pc_in;
          state <= T2;
        end
        T2: begin
          state <= T3;
        end
        T3: begin
          ir    <= ram_data;
          // Halt is detected on the incoming word so the machine parks in T4.
          if (ram_data[DATA_W-1 -: 4] == HLT_OP) hlt <= 1'b1;
          state <= T4;
        end
        T4: begin
          if (mem_ref) mar <= ir[ADDR_W-1:0];
          state <= T5;
        end
        T5: begin
          if (mem_ref) begin
            opr     <= ram_data;
            opr_vld <= 1'b1;
          end
          state <= T6;
        end
        T6: begin
          opr_vld <= 1'b0;
          count   <= count + 8'd1;
          state   <= T1;
        end
        default: begin
          state <= T1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_fetch_sequencer.sv
// Testbench for sap1_fetch_sequencer: randomized run/RAM stimulus against an instruction-step model.
// The bench supplies the PC (counts on Cp) and a combinational RAM indexed by mem_addr.
// Outputs are sampled 1 time unit after the falling edge, after inputs for the cycle are applied.
module tb_sap1_fetch_sequencer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       run = 1'b0;
  logic [3:0] pc;
  logic [7:0] ram_data;
  logic       Cp, Ep, operand_valid, out_strobe, halted;
  logic [3:0] mem_addr, opcode;
  logic [7:0] ir_out, operand, instr_count;
  logic [5:0] t_state;

  logic [7:0] ram [16];

  int n_checks = 0;
  int n_errors = 0;
  int ov_pulses = 0;
  int strobe_pulses = 0;

  // Reference model: instruction step 0..5 plus architectural register values.
  int         m_step;
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_opr, m_cnt;
  bit         m_ov, m_halt;

  always #5 CLK = ~CLK;

  // Environment PC: counts when the sequencer asks for it.
  always @(posedge CLK or posedge CLR) begin
    if (CLR) pc <= 4'h0;
    else if (Cp) pc <= pc + 4'h1;
  end

  assign ram_data = ram[mem_addr];

  sap1_fetch_sequencer dut (
    .CLK(CLK), .CLR(CLR), .run(run), .pc_in(pc), .ram_data(ram_data),
    .Cp(Cp), .Ep(Ep), .mem_addr(mem_addr), .ir_out(ir_out), .opcode(opcode),
    .operand(operand), .operand_valid(operand_valid), .out_strobe(out_strobe),
    .t_state(t_state), .halted(halted), .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_step = 0; m_pc = 0; m_mar = 0; m_ir = 0; m_opr = 0; m_cnt = 0;
    m_ov = 0; m_halt = 0;
  endtask

  // One rising edge of the machine as described in instruction terms.
  task automatic model_edge(input bit r);
    if (r && !m_halt) begin
      case (m_step)
        0: m_mar = m_pc;
        1: m_pc = m_pc + 4'h1;
        2: begin
          m_ir = ram[m_mar];
          if (m_ir[7:4] == 4'hF) m_halt = 1;
        end
        3: if (m_ir[7:4] < 4'd3) m_mar = m_ir[3:0];
        4: if (m_ir[7:4] < 4'd3) begin m_opr = ram[m_mar]; m_ov = 1; end
        5: begin m_ov = 0; m_cnt = m_cnt + 8'd1; end
        default: ;
      endcase
      m_step = (m_step + 1) % 6;
    end
  endtask

  task automatic check_all();
    check("t_state", {26'd0, t_state}, 32'd1 << m_step);
    check("mem_addr", {28'd0, mem_addr}, {28'd0, m_mar});
    check("ir_out", {24'd0, ir_out}, {24'd0, m_ir});
    check("opcode", {28'd0, opcode}, {28'd0, m_ir[7:4]});
    check("operand", {24'd0, operand}, {24'd0, m_opr});
    check("operand_valid", {31'd0, operand_valid}, {31'd0, m_ov});
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("instr_count", {24'd0, instr_count}, {24'd0, m_cnt});
    check("Ep", {31'd0, Ep}, {31'd0, m_step == 0});
    check("Cp", {31'd0, Cp}, {31'd0, (m_step == 1) && run && !m_halt});
    check("out_strobe", {31'd0, out_strobe},
          {31'd0, (m_step == 3) && (m_ir[7:4] == 4'hE) && !m_halt});
    check("pc", {28'd0, pc}, {28'd0, m_pc});
    if (operand_valid && m_step == 5) ov_pulses++;
    if (out_strobe) strobe_pulses++;
  endtask

  // Called at a falling edge; ends at the next falling edge.
  task automatic cycle(input bit r);
    run = r;
    #1;
    check_all();
    @(posedge CLK);
    model_edge(r);
    @(negedge CLK);
  endtask

  // Called at a falling edge; CLR rises mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    #2;
    CLR = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    @(negedge CLK);
    do_reset();

    // LDA 9 / OUT / HLT program.
    ram[0] = 8'h09; ram[1] = 8'hE0; ram[2] = 8'hF0; ram[9] = 8'h56;
    strobe_pulses = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check("lda_operand", {24'd0, operand}, 32'h56);
    check("lda_count", {24'd0, instr_count}, 32'd1);
    for (int i = 0; i < 40; i++) cycle(1'b1);
    check("hlt_halted", {31'd0, halted}, 32'd1);
    check("hlt_tstate", {26'd0, t_state}, 32'h08);
    check("hlt_count", {24'd0, instr_count}, 32'd2);
    check("hlt_pc", {28'd0, pc}, 32'd3);
    check("out_pulses", strobe_pulses, 32'd1);

    // Abort mid-T5 of an LDA with the operand load pending.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1);
    check("pre_abort_t5", {26'd0, t_state}, 32'h10);
    do_reset();
    check("abort_count", {24'd0, instr_count}, 32'd0);

    // Stall in T2 for 5 cycles: PC must advance exactly once.
    cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1);
    check("stall_pc", {28'd0, pc}, 32'd1);
    check("stall_count", {24'd0, instr_count}, 32'd1);

    // Random program (no HLT) with random run gating.
    do_reset();
    for (int i = 0; i < 16; i++)
      ram[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
    for (int i = 0; i < 600; i++) cycle($urandom_range(0, 3) != 0);

    // 256 no-ops: counter wraps and no operand is ever loaded.
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = {4'h3, 4'($urandom_range(0, 15))};
    ov_pulses = 0;
    for (int i = 0; i < 256 * 6; i++) cycle(1'b1);
    check("wrap_count", {24'd0, instr_count}, 32'd0);
    check("wrap_ov_pulses", ov_pulses, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
